reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file. It is the next generation of the core's 2-read/1-write register file.
- Adds the following:
  - N read ports.
  - Two write ports with defined priority.
  - Optional write-to-read bypass.
  - Per-register pending (scoreboard) bits with issue/flush control.
  - A pending-count output.
- Sits between decode/issue (reads, pending checks) and the writeback stage.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- ADDR_WIDTH, log2(DEPTH) = 5, address width.
- NUM_RD, 2, number of read ports; range 1..4.
- BYPASS, 1, 1 = read ports see same-cycle write data; 0 = reads return stored value only.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never pending.

Ports:
- clk  in  1  rising-edge clock.
- res  in  1  asynchronous reset, active-low.
- ra  in  NUM_RD*ADDR_WIDTH  read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd  out  NUM_RD*DATA_WIDTH  read data, packed the same way as ra.
- rd_pend  out  NUM_RD  pending bit of each read address.
- we  in  2  write enables, one per write port.
- wa  in  2*ADDR_WIDTH  write addresses.
- wd  in  2*DATA_WIDTH  write data.
- iss_v  in  1  issue valid; marks iss_a pending.
- iss_a  in  ADDR_WIDTH  destination register being issued.
- flush  in  1  synchronous clear of all pending bits.
- pend_cnt  out  ADDR_WIDTH+1  number of registers currently pending.

Behaviour:
- Reset (res=0, asynchronous):
  - All registers = 0, all pending bits = 0, pend_cnt = 0.
  - rd reflects zeros immediately; rd_pend = 0.
  - Reset held during operation overrides every other input.
- Writes:
  - Registered on the rising clk edge; stored value is visible one cycle later when BYPASS=0.
- Write priority:
  - Both ports enabled to the same address: port 1 data is stored.
  - Different addresses: both are stored.
- Register 0 with ZERO_REG=1:
  - Writes are ignored, reads return 0, issue is ignored, and its pending bit is constant 0.
- Read (combinational):
  - BYPASS=0: rd_k = REG[ra_k].
  - BYPASS=1: rd_k = wd of the highest-priority enabled port with wa == ra_k, else REG[ra_k].
  - Bypass never applies to address 0 when ZERO_REG=1.
- Pending bits:
  - Set at the clock edge when iss_v=1 (subject to the ZERO_REG rule).
  - Cleared at the edge when either write port writes that address.
  - Issue and write to the same address in the same cycle: the bit ends set, because issue wins (back-to-back producer).
  - Issue to an already-pending register: the bit stays set.
- rd_pend:
  - rd_pend_k = pend[ra_k], with no bypass.
  - BYPASS=1 only: rd_pend_k = 0 when a same-cycle write to ra_k is present and no same-address issue is present.
- flush=1:
  - Clears all pending bits at the edge and takes priority over issue.
  - Register writes in the same cycle still occur.
- pend_cnt:
  - Registered population count of the pending bits, updated the same edge as the bits.
  - Equals the count of the next-state bit vector, so it never lags the bits.
  - Maximum value is DEPTH-1 with ZERO_REG=1, or DEPTH without.
- Out-of-range parameters: elaboration-time error.

Test Plan:
1. Reset:
   - Write 0xDEADBEEF to reg 5, then assert res=0 mid-cycle.
   - rd for ra=5 becomes 0 immediately, without a clock edge; pend_cnt=0.
2. Dual write:
   - we=2'b11, wa0=wa1=7, wd0=0x11, wd1=0x22.
   - Next cycle reg7=0x22.
   - With wa0=3 and wa1=4 instead: reg3=0x11 and reg4=0x22.
3. Bypass:
   - BYPASS=1: same-cycle write reg9=0xA5A5 with ra0=9 gives rd0=0xA5A5 in that cycle.
   - BYPASS=0: rd0 shows the old value, then 0xA5A5 next cycle.
4. Zero register:
   - Write 0xFFFF to reg0 and issue reg0.
   - rd=0, rd_pend=0, pend_cnt unchanged.
5. Scoreboard:
   - Issue 4, issue 6: pend_cnt=2.
   - Write reg4 and issue reg4 in the same cycle: pend4 stays 1, pend_cnt=2.
   - Write reg6: pend_cnt=1.
   - flush together with iss_a=8: pend_cnt=0.
6. Fill:
   - Issue regs 1..31 on consecutive cycles: pend_cnt reaches 31.
   - Single write to reg 31 ... no, to reg 20: pend_cnt=30 and rd_pend for reg 20 = 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: N read ports, two prioritised write
// ports, optional write-to-read bypass and per-register pending bits.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd,
    output logic [NUM_RD-1:0]            rd_pend,
    input  logic [1:0]                   we,
    input  logic [2*ADDR_WIDTH-1:0]      wa,
    input  logic [2*DATA_WIDTH-1:0]      wd,
    input  logic                         iss_v,
    input  logic [ADDR_WIDTH-1:0]        iss_a,
    input  logic                         flush,
    output logic [ADDR_WIDTH:0]          pend_cnt
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        ADDR_WIDTH != $clog2(DEPTH) || NUM_RD < 1 || NUM_RD > 4 ||
        DATA_WIDTH < 1 || (BYPASS != 0 && BYPASS != 1) ||
        (ZERO_REG != 0 && ZERO_REG != 1)) begin : g_bad_param
        $error("reg_file_mp: illegal parameter set");
    end

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_pend;
    logic [ADDR_WIDTH:0]   r_cnt;

    logic [ADDR_WIDTH-1:0] w_wa0;
    logic [ADDR_WIDTH-1:0] w_wa1;
    logic [DATA_WIDTH-1:0] w_wd0;
    logic [DATA_WIDTH-1:0] w_wd1;
    logic [DEPTH-1:0]      w_hit0;
    logic [DEPTH-1:0]      w_hit1;
    logic [DEPTH-1:0]      w_pend_nxt;
    logic [ADDR_WIDTH:0]   w_cnt_nxt;
    logic                  w_byp;

    assign w_wa0 = wa[0 +: ADDR_WIDTH];
    assign w_wa1 = wa[ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wd0 = wd[0 +: DATA_WIDTH];
    assign w_wd1 = wd[DATA_WIDTH +: DATA_WIDTH];
    assign w_byp = (BYPASS != 0) && res;

    // Issue beats a same-cycle write so back-to-back producers stay pending
    always_comb begin
        w_hit0     = '0;
        w_hit1     = '0;
        w_pend_nxt = '0;
        w_cnt_nxt  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit0[i] = we[0] && (w_wa0 == ADDR_WIDTH'(i));
            w_hit1[i] = we[1] && (w_wa1 == ADDR_WIDTH'(i));
        end
        if (ZERO_REG != 0) begin
            w_hit0[0] = 1'b0;
            w_hit1[0] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush)
                w_pend_nxt[i] = 1'b0;
            else if (iss_v && iss_a == ADDR_WIDTH'(i))
                w_pend_nxt[i] = 1'b1;
            else if (w_hit0[i] || w_hit1[i])
                w_pend_nxt[i] = 1'b0;
            else
                w_pend_nxt[i] = r_pend[i];
        end
        if (ZERO_REG != 0)
            w_pend_nxt[0] = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            w_cnt_nxt = w_cnt_nxt + {{ADDR_WIDTH{1'b0}}, w_pend_nxt[i]};
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_hit1[i])
                    r_regs[i] <= w_wd1;
                else if (w_hit0[i])
                    r_regs[i] <= w_wd0;
            end
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign pend_cnt = r_cnt;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_a;
        logic [DATA_WIDTH-1:0] w_d;
        logic                  w_z;
        logic                  w_wr;
        logic                  w_iss;

        assign w_a   = ra[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_z   = (ZERO_REG != 0) && (w_a == '0);
        assign w_wr  = w_byp && (w_hit0[w_a] || w_hit1[w_a]);
        assign w_iss = iss_v && (iss_a == w_a);

        assign w_d = w_z                      ? '0 :
                     (w_byp && w_hit1[w_a])   ? w_wd1 :
                     (w_byp && w_hit0[w_a])   ? w_wd0 :
                     r_regs[w_a];

        assign rd[k*DATA_WIDTH +: DATA_WIDTH] = w_d;
        assign rd_pend[k] = !w_z && r_pend[w_a] && !(w_wr && !w_iss);
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: three configurations share stimulus,
// a reference model predicts every cycle and a monitor compares.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam bit [2:0] ZC = 3'b011;
    localparam bit [2:0] BC = 3'b101;

    typedef struct packed {
        logic [2:0][63:0] rd;
        logic [2:0][1:0]  rp;
        logic [2:0][5:0]  cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          res;
    logic [2*AW-1:0] ra;
    logic [1:0]    we;
    logic [2*AW-1:0] wa;
    logic [2*DW-1:0] wd;
    logic          iss_v;
    logic [AW-1:0] iss_a;
    logic          flush;

    logic [63:0] rd_0, rd_1, rd_2;
    logic [1:0]  rp_0, rp_1, rp_2;
    logic [5:0]  cnt_0, cnt_1, cnt_2;

    logic [DW-1:0] m_reg [3][32];
    bit            m_pend [3][32];
    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1), .ZERO_REG(1)) u_dut0 (
        .clk(clk), .res(res), .ra(ra), .rd(rd_0), .rd_pend(rp_0),
        .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_a(iss_a),
        .flush(flush), .pend_cnt(cnt_0));

    reg_file_mp #(.BYPASS(0), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .res(res), .ra(ra), .rd(rd_1), .rd_pend(rp_1),
        .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_a(iss_a),
        .flush(flush), .pend_cnt(cnt_1));

    reg_file_mp #(.BYPASS(1), .ZERO_REG(0)) u_dut2 (
        .clk(clk), .res(res), .ra(ra), .rd(rd_2), .rd_pend(rp_2),
        .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_a(iss_a),
        .flush(flush), .pend_cnt(cnt_2));

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < 32; i++) begin
                m_reg[n][i]  = '0;
                m_pend[n][i] = 1'b0;
            end
    endtask

    // Apply the effect of the clock edge that just happened
    task automatic model_edge();
        logic [4:0] a0, a1;
        a0 = wa[0 +: AW];
        a1 = wa[AW +: AW];
        if (!res) begin
            model_clear();
            return;
        end
        for (int n = 0; n < 3; n++) begin
            if (we[0] && !(ZC[n] && a0 == 0)) m_reg[n][a0] = wd[0 +: DW];
            if (we[1] && !(ZC[n] && a1 == 0)) m_reg[n][a1] = wd[DW +: DW];
            if (flush) begin
                for (int i = 0; i < 32; i++) m_pend[n][i] = 1'b0;
            end else begin
                if (we[0]) m_pend[n][a0] = 1'b0;
                if (we[1]) m_pend[n][a1] = 1'b0;
                if (iss_v) m_pend[n][iss_a] = 1'b1;
                if (ZC[n]) m_pend[n][0] = 1'b0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        for (int n = 0; n < 3; n++) begin
            int c;
            c = 0;
            for (int i = 0; i < 32; i++) c += int'(m_pend[n][i]);
            e.cnt[n] = 6'(c);
            for (int k = 0; k < 2; k++) begin
                logic [4:0]  a;
                logic [31:0] d;
                logic        p, wr;
                a  = ra[k*AW +: AW];
                d  = m_reg[n][a];
                p  = m_pend[n][a];
                wr = (we[0] && wa[0 +: AW] == a) || (we[1] && wa[AW +: AW] == a);
                if (BC[n] && res) begin
                    if (we[1] && wa[AW +: AW] == a) d = wd[DW +: DW];
                    else if (we[0] && wa[0 +: AW] == a) d = wd[0 +: DW];
                    if (wr && !(iss_v && iss_a == a)) p = 1'b0;
                end
                if (ZC[n] && a == 0) begin
                    d = '0;
                    p = 1'b0;
                end
                e.rd[n][k*32 +: 32] = d;
                e.rp[n][k] = p;
            end
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic [4:0] r0, r1,
                        input logic [1:0] w, input logic [4:0] a0, a1,
                        input logic [31:0] d0, d1, input logic iv,
                        input logic [4:0] ia, input logic fl);
        @(posedge clk);
        model_edge();
        #1;
        res = r; ra = {r1, r0}; we = w; wa = {a1, a0}; wd = {d1, d0};
        iss_v = iv; iss_a = ia; flush = fl;
        if (!res) model_clear();
        sb.push_back(model_out());
    endtask

    task automatic idle(input logic [4:0] r0, r1);
        step(1'b1, r0, r1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    endtask

    function automatic logic [4:0] rnd_a();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            logic [2:0][63:0] ar;
            logic [2:0][1:0]  ap;
            logic [2:0][5:0]  ac;
            e  = sb.pop_front();
            ar = {rd_2, rd_1, rd_0};
            ap = {rp_2, rp_1, rp_0};
            ac = {cnt_2, cnt_1, cnt_0};
            for (int n = 0; n < 3; n++) begin
                for (int k = 0; k < 2; k++)
                    chk($sformatf("rd i%0d p%0d", n, k),
                        {32'd0, ar[n][k*32 +: 32]}, {32'd0, e.rd[n][k*32 +: 32]});
                chk($sformatf("rd_pend i%0d", n), {62'd0, ap[n]}, {62'd0, e.rp[n]});
                chk($sformatf("pend_cnt i%0d", n), {58'd0, ac[n]}, {58'd0, e.cnt[n]});
            end
        end
    end

    initial begin
        res = 1'b0; ra = '0; we = '0; wa = '0; wd = '0;
        iss_v = 1'b0; iss_a = '0; flush = 1'b0;
        model_clear();
        step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        idle(5'd0, 5'd0);

        step(1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 1'b1, 5'd5, 1'b0);
        idle(5'd5, 5'd0);
        #5 chk("reg5 before reset", {32'd0, rd_1[31:0]}, 64'hDEADBEEF);
        step(1'b0, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        #5 chk("reg5 in reset", {32'd0, rd_0[31:0]}, 64'd0);
        chk("cnt in reset", {58'd0, cnt_0}, 64'd0);
        idle(5'd5, 5'd0);

        step(1'b1, 5'd7, 5'd0, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 1'b0);
        idle(5'd7, 5'd0);
        #5 chk("dual write same addr", {32'd0, rd_1[31:0]}, 64'h22);
        step(1'b1, 5'd3, 5'd4, 2'b11, 5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 5'd0, 1'b0);
        idle(5'd3, 5'd4);
        #5 chk("dual write diff addr", rd_1, {32'h22, 32'h11});

        step(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 32'hA5A5, 32'd0, 1'b0, 5'd0, 1'b0);
        #5 chk("bypass on", {32'd0, rd_0[31:0]}, 64'hA5A5);
        chk("bypass off", {32'd0, rd_1[31:0]}, 64'd0);
        idle(5'd9, 5'd0);

        step(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 32'hFFFF, 32'd0, 1'b1, 5'd0, 1'b0);
        idle(5'd0, 5'd0);

        step(1'b1, 5'd4, 5'd6, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd4, 1'b0);
        step(1'b1, 5'd4, 5'd6, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd6, 1'b0);
        step(1'b1, 5'd4, 5'd6, 2'b01, 5'd4, 5'd0, 32'h44, 32'd0, 1'b1, 5'd4, 1'b0);
        step(1'b1, 5'd4, 5'd6, 2'b01, 5'd6, 5'd0, 32'h66, 32'd0, 1'b0, 5'd0, 1'b0);
        #5 chk("cnt after issue 4,6", {58'd0, cnt_0}, 64'd2);
        step(1'b1, 5'd8, 5'd4, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd8, 1'b1);
        idle(5'd8, 5'd4);
        #5 chk("cnt after flush", {58'd0, cnt_0}, 64'd0);

        for (int i = 1; i < 32; i++)
            step(1'b1, 5'(i), 5'd20, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'(i), 1'b0);
        step(1'b1, 5'd20, 5'd31, 2'b10, 5'd0, 5'd20, 32'd0, 32'h2020, 1'b0, 5'd0, 1'b0);
        #5 chk("cnt full", {58'd0, cnt_0}, 64'd31);
        idle(5'd20, 5'd31);
        #5 chk("cnt after write 20", {58'd0, cnt_0}, 64'd30);
        chk("rd_pend reg20", {63'd0, rp_0[0]}, 64'd0);

        repeat (600) begin
            logic [1:0] w;
            w = 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 63) != 0), rnd_a(), rnd_a(), w,
                 rnd_a(), rnd_a(), $urandom, $urandom,
                 1'($urandom_range(0, 1)), rnd_a(),
                 1'($urandom_range(0, 11) == 0));
        end

        idle(5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
